switcher_cfg_ctrl: RTL

- Sequencer and arbiter for the 8-line switcher's 3-wire serial configuration port (sw_reset, sw_clk, sw_sda).
- Accepts 8-bit route words from two requesters over valid/ready and grants one word at a time, round-robin.
- Generates the complete load sequence for the granted word: reset edge, dummy edge, then 8 data edges, LSB first. Keeps a shadow of the last committed word.

---
 rtl/switcher_pkg.sv | 9 +
 rtl/rr_arb2.sv | 25 ++
 rtl/switcher_cfg_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/switcher_pkg.sv
// Shared types and constants for the switcher configuration controller.
package switcher_pkg;

   typedef enum logic [2:0] {IDLE, RST, DUMMY, SHIFT, DONE} state_t;

   localparam int SW_NBITS     = 8;
   localparam int SW_PRE_EDGES = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arb2
   import switcher_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
   end

   // last starts at 1 so requester 0 wins the first contention after reset
   always_ff @(posedge clk) begin
      if (reset)       last <= 1'b1;
      else if (accept) last <= gnt[1];
   end

endmodule

// File: rtl/switcher_cfg_ctrl.sv
// Arbitrates two route-word requesters and serialises the granted word onto the
// switcher's reset/clock/data port: reset edge, dummy edge, then NBITS data edges LSB first.
module switcher_cfg_ctrl
   import switcher_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int NBITS   = SW_NBITS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [NBITS-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [NBITS-1:0] req1_data,
   output logic             req1_ready,
   output logic             sw_reset,
   output logic             sw_clk,
   output logic             sw_sda,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [NBITS-1:0] cfg_shadow,
   output logic             cfg_valid
);

   localparam int HC_W = $clog2(CLK_DIV) + 1;
   localparam int BC_W = $clog2(NBITS + 1);
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(NBITS - 1);

   state_t           state, state_nxt;
   logic [HC_W-1:0]  hcnt, hcnt_nxt;
   logic [BC_W-1:0]  bcnt, bcnt_nxt;
   logic [NBITS-1:0] word, shreg, shreg_nxt;
   logic             gid;
   logic [1:0]       gnt;
   logic             accept, half_end, period_end, last_bit;
   logic             sw_reset_nxt, sw_clk_nxt, sw_sda_nxt;
   logic             busy_nxt, done_nxt, done_id_nxt, cfg_valid_nxt;
   logic [NBITS-1:0] cfg_shadow_nxt;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({req1_valid, req0_valid}),
      .accept (accept),
      .gnt    (gnt)
   );

   // ready is gated by reset so a word cannot appear accepted during a reset cycle
   assign req0_ready = (state == IDLE) && !reset && gnt[0];
   assign req1_ready = (state == IDLE) && !reset && gnt[1];
   assign accept     = req0_ready || req1_ready;

   assign half_end   = (hcnt == HC_LAST);
   assign period_end = sw_clk && half_end;
   assign last_bit   = (bcnt == BC_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RST;
         RST:     if (period_end) state_nxt = DUMMY;
         DUMMY:   if (period_end) state_nxt = SHIFT;
         SHIFT:   if (period_end && last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Line values for the next period are set on the edge that ends the previous high phase.
   always_comb begin
      hcnt_nxt       = '0;
      bcnt_nxt       = bcnt;
      shreg_nxt      = shreg;
      sw_reset_nxt   = sw_reset;
      sw_clk_nxt     = sw_clk;
      sw_sda_nxt     = sw_sda;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      done_id_nxt    = done_id;
      cfg_shadow_nxt = cfg_shadow;
      cfg_valid_nxt  = cfg_valid;
      case (state)
         IDLE: begin
            sw_reset_nxt = accept;
            sw_clk_nxt   = 1'b0;
            sw_sda_nxt   = 1'b0;
            busy_nxt     = accept;
         end
         RST, DUMMY, SHIFT: begin
            hcnt_nxt = half_end ? '0 : hcnt + 1'b1;
            if (half_end) sw_clk_nxt = !sw_clk;
            if (period_end) begin
               sw_reset_nxt = 1'b0;
               if (state == RST) begin
                  sw_sda_nxt = 1'b0;
               end else if (state == DUMMY) begin
                  sw_sda_nxt = word[0];
                  shreg_nxt  = word >> 1;
                  bcnt_nxt   = '0;
               end else if (!last_bit) begin
                  sw_sda_nxt = shreg[0];
                  shreg_nxt  = shreg >> 1;
                  bcnt_nxt   = bcnt + 1'b1;
               end else begin
                  sw_sda_nxt     = 1'b0;
                  done_nxt       = 1'b1;
                  done_id_nxt    = gid;
                  cfg_shadow_nxt = word;
                  cfg_valid_nxt  = 1'b1;
               end
            end
         end
         DONE:    busy_nxt = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         word <= gnt[1] ? req1_data : req0_data;
         gid  <= gnt[1];
      end
      shreg <= shreg_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt       <= '0;
         bcnt       <= '0;
         sw_reset   <= 1'b1;
         sw_clk     <= 1'b0;
         sw_sda     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_id    <= 1'b0;
         cfg_shadow <= '0;
         cfg_valid  <= 1'b0;
      end else begin
         hcnt       <= hcnt_nxt;
         bcnt       <= bcnt_nxt;
         sw_reset   <= sw_reset_nxt;
         sw_clk     <= sw_clk_nxt;
         sw_sda     <= sw_sda_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         done_id    <= done_id_nxt;
         cfg_shadow <= cfg_shadow_nxt;
         cfg_valid  <= cfg_valid_nxt;
      end
   end

endmodule
